// File: rtl/if_id_skid_reg_pkg.sv
// Shared pipeline package for the stage registers.
// Holds the skid-buffer FSM encoding, the architectural NOP and a PC/instruction
// entry type that the later stage registers (ID/EX, EX/MEM) reuse at the
// default widths.
package if_id_skid_reg_pkg;

   localparam int          PC_W_DEF      = 64;
   localparam int          INSTR_W_DEF   = 32;
   localparam logic [31:0] NOP_INSTR_DEF = 32'hD503201F;   // AArch64 NOP

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_t;

   typedef struct packed {
      logic [PC_W_DEF-1:0]    pc;
      logic [INSTR_W_DEF-1:0] instr;
   } pipe_entry_t;

endpackage

// File: rtl/if_id_skid_reg_sat_counter.sv
// sat_counter: saturating up-counter for pipeline performance events.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, clears the count
//   inc   - add one this cycle (ignored once the count is all ones)
//   count - current value, sticks at 2^CNT_W-1
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID pipeline register built as a two-entry skid buffer.
// Fetch pushes with in_valid/in_ready, decode pops with out_valid/out_ready.
// in_ready comes straight from a flop so fetch never sees a combinational
// path back from decode; the skid entry absorbs the word that was already in
// flight when decode stalled.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - fetch handshake (in_ready registered)
//   in_pc/in_instr      - fetched word, ignored when in_valid=0
//   out_valid/out_ready - decode handshake (out_ready low = hazard stall)
//   out_pc/out_instr    - head entry; out_instr is NOP_INSTR when invalid
//   flush               - branch redirect, empties the buffer
//   stall_cnt           - saturating count of cycles decode held a valid word
module if_id_skid_reg
   import if_id_skid_reg_pkg::*;
#(
   parameter int                 PC_W      = PC_W_DEF,
   parameter int                 INSTR_W   = INSTR_W_DEF,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
   parameter int                 CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   input  logic               flush,
   output logic [CNT_W-1:0]   stall_cnt
);

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   skid_state_t r_state, w_state_nxt;
   entry_t      r_head, r_skid, w_in_entry;
   logic        r_in_ready;
   logic        w_push, w_pop;
   logic        w_ld_head_in, w_ld_head_skid, w_ld_skid;
   logic        w_stall_inc;

   assign w_in_entry = '{pc: in_pc, instr: in_instr};
   assign w_push     = in_valid & r_in_ready;
   assign out_valid  = (r_state != ST_EMPTY);
   assign w_pop      = out_valid & out_ready;

   // Next state and entry load enables. Flush wins over any push/pop.
   always_comb begin
      w_state_nxt    = r_state;
      w_ld_head_in   = 1'b0;
      w_ld_head_skid = 1'b0;
      w_ld_skid      = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_push) begin
                  w_state_nxt  = ST_ONE;
                  w_ld_head_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_push && !w_pop) begin
                  w_state_nxt = ST_FULL;
                  w_ld_skid   = 1'b1;
               end else if (w_push && w_pop) begin
                  w_ld_head_in = 1'b1;
               end else if (w_pop) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only a pop can happen.
               if (w_pop) begin
                  w_state_nxt    = ST_ONE;
                  w_ld_head_skid = 1'b1;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // in_ready is precomputed from the next state so it is a pure flop output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_FULL);
      end
   end

   // Entries are not cleared on flush; out_valid masks the stale head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head <= '0;
         r_skid <= '0;
      end else begin
         if (w_ld_head_in) begin
            r_head <= w_in_entry;
         end else if (w_ld_head_skid) begin
            r_head <= r_skid;
         end
         if (w_ld_skid) begin
            r_skid <= w_in_entry;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_pc    = r_head.pc;
   assign out_instr = out_valid ? r_head.instr : NOP_INSTR;

   assign w_stall_inc = out_valid & ~out_ready & ~flush;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_stall_inc),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;

   localparam int          CW   = 4;
   localparam logic [31:0] NOP  = 32'hD503201F;
   localparam logic [CW-1:0] CMAX = {CW{1'b1}};

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready, flush;
   logic [63:0]   in_pc, out_pc;
   logic [31:0]   in_instr, out_instr;
   logic [CW-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   if_id_skid_reg #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .flush(flush), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: a FIFO of at most two words plus a saturating counter.
   typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
   ent_t          mq[$];
   logic [CW-1:0] mcnt;

   // Apply inputs (called at negedge), advance model at posedge, return at negedge.
   task automatic step(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
      logic push, pop;
      in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
      @(posedge clk);
      if (!rst_n) begin
         mq.delete(); mcnt = '0;
      end else begin
         push = v && (mq.size() < 2);
         pop  = (mq.size() > 0) && ordy;
         if ((mq.size() > 0) && !ordy && !fl && (mcnt != CMAX)) mcnt = mcnt + 1'b1;
         if (fl) mq.delete();
         else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back('{pc, ins});
         end
      end
      @(negedge clk);
   endtask

   // Expected {in_ready, out_valid, pc, instr, stall_cnt}; pc is don't-care (0) when empty.
   function automatic logic [101:0] exp_vec();
      logic [63:0] p = '0;
      logic [31:0] i = NOP;
      if (mq.size() > 0) begin p = mq[0].pc; i = mq[0].instr; end
      return {(mq.size() < 2), (mq.size() > 0), p, i, mcnt};
   endfunction

   function automatic logic [101:0] got_vec();
      return {in_ready, out_valid, (out_valid ? out_pc : 64'd0), out_instr, stall_cnt};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) step(1'b1, 64'hDEAD, 32'hBEEF, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || out_instr !== NOP || in_ready !== 1'b1 ||
          stall_cnt !== '0 || out_pc !== 64'd0) begin
         errors++;
         $display("FAIL reset_vals got v=%b i=%h r=%b c=%0d pc=%h want v=0 i=%h r=1 c=0 pc=0",
                  out_valid, out_instr, in_ready, stall_cnt, out_pc, NOP);
      end
      rst_n = 1'b1;
      step(1'b1, 64'h1000, 32'h8B020020, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'h1000 || out_instr !== 32'h8B020020) begin
         errors++;
         $display("FAIL first_push got v=%b pc=%h i=%h want v=1 pc=1000 i=8b020020",
                  out_valid, out_pc, out_instr);
      end
      checks++;
      if (got_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL first_push_model got %h want %h", got_vec(), exp_vec());
      end
   endtask

   task automatic test_streaming();
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 64'(k * 4), $urandom, 1'b1, 1'b0);
         checks++;
         if (out_pc !== 64'(k * 4) || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stream[%0d] got pc=%h r=%b v=%b want pc=%h r=1 v=1",
                     k, out_pc, in_ready, out_valid, 64'(k * 4));
         end
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL stream_model[%0d] got %h want %h", k, got_vec(), exp_vec());
         end
      end
      step(1'b0, '0, '0, 1'b1, 1'b0);   // drain
   endtask

   task automatic test_skid_fill();
      step(1'b1, 64'h10, 32'h11111111, 1'b0, 1'b0);
      step(1'b1, 64'h14, 32'h22222222, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b0);
      checks++;
      if (in_ready !== 1'b0 || out_pc !== 64'h10 || out_instr !== 32'h11111111) begin
         errors++;
         $display("FAIL skid_full got r=%b pc=%h i=%h want r=0 pc=10 i=11111111",
                  in_ready, out_pc, out_instr);
      end
      step(1'b0, '0, '0, 1'b1, 1'b0);
      checks++;
      if (in_ready !== 1'b1 || out_pc !== 64'h14 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL skid_pop1 got r=%b pc=%h v=%b want r=1 pc=14 v=1",
                  in_ready, out_pc, out_valid);
      end
      step(1'b0, '0, '0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || got_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL skid_drain got %h want %h", got_vec(), exp_vec());
      end
   endtask

   task automatic test_flush();
      step(1'b1, 64'h20, 32'hAAAA0000, 1'b0, 1'b0);
      step(1'b1, 64'h24, 32'hAAAA0001, 1'b0, 1'b0);
      step(1'b1, 64'h28, 32'hAAAA0002, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || out_instr !== NOP || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush got v=%b i=%h r=%b want v=0 i=%h r=1",
                  out_valid, out_instr, in_ready, NOP);
      end
      step(1'b0, '0, '0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || got_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL flush_nocapture got %h want %h", got_vec(), exp_vec());
      end
   endtask

   task automatic test_stall_cnt();
      rst_n = 1'b0;
      step(1'b0, '0, '0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step(1'b1, 64'h50, 32'h12345678, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         step(1'b0, {$urandom, $urandom}, $urandom, 1'b0, 1'b0);
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL stall[%0d] got %h want %h", k, got_vec(), exp_vec());
         end
      end
      checks++;
      if (stall_cnt !== CMAX || out_pc !== 64'h50) begin
         errors++;
         $display("FAIL stall_sat got c=%0d pc=%h want c=%0d pc=50", stall_cnt, out_pc, CMAX);
      end
   endtask

   task automatic test_random();
      rst_n = 1'b0;
      step(1'b0, '0, '0, 1'b0, 1'b0);
      rst_n = 1'b1;
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom,
              $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random[%0d] got %h want %h", k, got_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_async_reset();
      step(1'b0, '0, '0, 1'b0, 1'b1);
      step(1'b1, 64'h60, 32'h0000AAAA, 1'b0, 1'b0);
      step(1'b1, 64'h64, 32'h0000BBBB, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b0);
      checks++;
      if (got_vec() !== exp_vec() || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL async_pre got %h want %h", got_vec(), exp_vec());
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_instr !== NOP || in_ready !== 1'b1 ||
          stall_cnt !== '0 || out_pc !== 64'd0) begin
         errors++;
         $display("FAIL async_reset got v=%b i=%h r=%b c=%0d pc=%h want v=0 i=%h r=1 c=0 pc=0",
                  out_valid, out_instr, in_ready, stall_cnt, out_pc, NOP);
      end
      mq.delete(); mcnt = '0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 64'h70, 32'h0000CCCC, 1'b1, 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL async_recover got %h want %h", got_vec(), exp_vec());
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      in_pc = '0; in_instr = '0; mcnt = '0;
      @(negedge clk);
      test_reset();
      test_streaming();
      test_skid_fill();
      test_flush();
      test_stall_cnt();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
